// File: rtl/workout_sequencer.sv
// workout_sequencer: IDLE/WORK/REST/DONE phase controller with a prescaled
// 1-second countdown, exercise index, pause and skip handling.
module workout_sequencer #(
  parameter int TICK_DIV     = 40000000,
  parameter bit SIM_SPEEDUP  = 1'b0,
  parameter int SIM_TICK_DIV = 20,
  parameter int DONE_SECS    = 3
) (
  input  logic       clk_40MHz,
  input  logic       rst_n,
  input  logic       start_pulse,
  input  logic       skip_pulse,
  input  logic [8:0] total_exercises,
  input  logic [6:0] work_secs,
  input  logic [6:0] rest_secs,
  output logic [1:0] workout_state,
  output logic [8:0] current_exercise_num,
  output logic [6:0] countdown_seconds,
  output logic       paused,
  output logic       buzz_pulse
);
  typedef enum logic [1:0] {IDLE = 2'b00, WORK = 2'b01, REST = 2'b10, DONE = 2'b11} state_t;
  localparam int DIV = SIM_SPEEDUP ? SIM_TICK_DIV : TICK_DIV;
  localparam logic [31:0] DIV_M1 = 32'(DIV - 1);
  localparam logic [6:0] DONE_CD = 7'(DONE_SECS);
  state_t r_state;
  logic [31:0] r_presc;
  logic [8:0] r_total;
  logic [6:0] r_work, r_rest;
  logic w_active, w_tick, w_exp, w_adv, w_last;
  state_t w_next;
  assign workout_state = r_state;
  assign w_active = (r_state == WORK) || (r_state == REST);
  assign w_tick = (r_state != IDLE) && !paused && (r_presc == DIV_M1);
  assign w_exp = w_tick && (countdown_seconds == 7'd1);
  // skip outranks a same-cycle tick, so at most one advance happens per cycle
  assign w_adv = w_active && (skip_pulse || w_exp);
  assign w_last = current_exercise_num == r_total;
  assign w_next = (r_state == WORK && w_last) ? DONE :
                  (r_state == WORK && !skip_pulse && r_rest != '0) ? REST : WORK;
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_total <= '0;
      r_work <= '0;
      r_rest <= '0;
      current_exercise_num <= '0;
      countdown_seconds <= '0;
      paused <= 1'b0;
      buzz_pulse <= 1'b0;
    end else begin
      buzz_pulse <= 1'b0;
      if (r_state == IDLE) begin
        if (start_pulse && total_exercises != '0 && work_secs != '0) begin
          r_total <= total_exercises;
          r_work <= work_secs;
          r_rest <= rest_secs;
          r_state <= WORK;
          current_exercise_num <= 9'd1;
          countdown_seconds <= work_secs;
          buzz_pulse <= 1'b1;
        end
      end else if (w_adv) begin
        r_state <= w_next;
        r_presc <= '0;
        paused <= 1'b0;
        buzz_pulse <= 1'b1;
        countdown_seconds <= (w_next == DONE) ? DONE_CD : (w_next == REST) ? r_rest : r_work;
        if (w_next == WORK) current_exercise_num <= current_exercise_num + 9'd1;
      end else if (r_state == DONE && w_exp) begin
        r_state <= IDLE;
        r_presc <= '0;
        current_exercise_num <= '0;
        countdown_seconds <= '0;
      end else begin
        if (w_tick) countdown_seconds <= countdown_seconds - 7'd1;
        if (!paused) r_presc <= w_tick ? '0 : r_presc + 32'd1;
        if (start_pulse && w_active) paused <= !paused;
      end
    end
  end
endmodule
